wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline WB stage
//  (MEM2WB outputs) and a long-latency unit (mul/div) that completes out of band.
//  LU results are buffered in a small FIFO. The pipeline has priority. A starvation
//  counter forces a one-cycle pipeline stall so the FIFO head can drain.
//  Sits between MEM2WB / the LU result bus and the register file write port.
// PARAMETERS
//  WORD_W    `WORD_LEN           data width
//  ADDR_W    `REG_FILE_ADDR_LEN  register address width
//  DEPTH     4                   LU result FIFO entries (power of 2, >=2)
//  MAX_WAIT  8                   blocked cycles before forced drain (>=1)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous reset, active-low
//  wb_en         in   1       MEM2WB WB_EN
//  mem_r_en      in   1       MEM2WB MEM_R_EN: selects mem_read_val, else alu_res
//  wb_dest       in   ADDR_W  MEM2WB dest
//  alu_res       in   WORD_W  MEM2WB ALURes
//  mem_read_val  in   WORD_W  MEM2WB memReadVal
//  lu_valid      in   1       LU result valid
//  lu_dest       in   ADDR_W  LU destination register
//  lu_data       in   WORD_W  LU result
//  lu_ready      out  1       FIFO can accept (= !full)
//  pipe_stall    out  1       freeze MEM2WB and earlier stages this cycle
//  rf_we         out  1       register file write enable
//  rf_waddr      out  ADDR_W  register file write address
//  rf_wdata      out  WORD_W  register file write data
// BEHAVIOUR
//  - FSM states: IDLE, DRAIN. State, FIFO pointers, count and wait_cnt are flops.
//    Port outputs are combinational from flops and inputs, with no added latency.
//  - Reset (async, rst_n=0): state=IDLE, FIFO empty, wait_cnt=0. Results: lu_ready=1,
//    pipe_stall=0, rf_we=0, rf_waddr=0, rf_wdata=0. Mid-operation reset discards
//    buffered entries.
//  - Push: at the edge when lu_valid && lu_ready. lu_ready depends only on full,
//    so a full FIFO refuses a push even if it pops the same cycle.
//  - There is no push-to-write bypass. A pushed entry is writable from the next cycle.
//  - IDLE: if wb_en=1, the pipeline owns the port: rf_we=1, rf_waddr=wb_dest,
//    rf_wdata=mem_r_en?mem_read_val:alu_res. Otherwise, if the FIFO is non-empty,
//    pop the head (rf_we=1, head dest/data). Otherwise rf_we=0 and addr/data=0.
//  - wait_cnt: clears on any pop and whenever the FIFO is empty. It increments each
//    IDLE cycle the FIFO is non-empty and wb_en=1 (head blocked).
//  - IDLE->DRAIN at the edge where the head is blocked and wait_cnt==MAX_WAIT-1.
//    DRAIN is entered after MAX_WAIT consecutive blocked cycles.
//  - DRAIN (1 cycle): pipe_stall=1, pop and write the head regardless of wb_en.
//    MEM2WB holds its entry, which writes next cycle. Then wait_cnt=0 and ->IDLE.
//  - Simultaneous push and pop: both occur and count is unchanged. Pointers wrap
//    modulo DEPTH.
//  - Same-register ordering between LU and pipeline writes is the issue logic's
//    duty, not this block's.
// CONFIGURATION
//  WB_ARB_STATS_EN defined: adds output stall_cycles[15:0], which counts DRAIN
//    cycles, saturates at 16'hFFFF and resets to 0.
//  WB_ARB_STATS_EN undefined: the port and counter are absent, and behaviour is
//    otherwise identical.
// TESTING
//  1 Reset: rst_n=0 mid-traffic with 3 entries buffered -> all outputs at reset
//    values async. After release, lu_ready=1 and no stale writes.
//  2 Pipeline only: wb_en=1, mem_r_en=1, dest=5, mem_read_val=0xDEAD_BEEF ->
//    same cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
//    With mem_r_en=0 -> wdata=alu_res.
//  3 Idle slot: push lu_dest=3, lu_data=0x1234 in cycle 0, wb_en=0 ->
//    cycle 1 rf_we=1, waddr=3, wdata=0x1234. Cycle 2 FIFO empty.
//  4 Starvation (MAX_WAIT=8): wb_en held 1, push in cycle 0 -> cycles 1-8 pipeline
//    writes. Cycle 9 pipe_stall=1 and LU entry written. Cycle 10 pipe_stall=0.
//  5 Full: push 4 entries with wb_en=1 -> lu_ready=0. A 5th lu_valid is not
//    accepted. Order is preserved on drain, and lu_ready returns the cycle after
//    the first pop.
//  6 Stats (WB_ARB_STATS_EN): run scenario 4 twice -> stall_cycles=2.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and a
// long-latency unit (mul/div). LU results wait in a small FIFO and take idle
// write slots. The pipeline has priority. If the FIFO head stays blocked for
// MAX_WAIT consecutive cycles, a one-cycle DRAIN stalls the pipeline and
// writes the head instead.
// Optional feature macro: WB_ARB_STATS_EN adds the stall_cycles[15:0] counter
// output, which counts DRAIN cycles and saturates.

`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif

module wb_port_arbiter #(
    parameter int WORD_W   = `WORD_LEN,
    parameter int ADDR_W   = `REG_FILE_ADDR_LEN,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [WORD_W-1:0] alu_res,
    input  logic [WORD_W-1:0] mem_read_val,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_dest,
    input  logic [WORD_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [WORD_W-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    // state   | meaning
    // S_IDLE  | pipeline owns the port; FIFO head takes slots where wb_en=0
    // S_DRAIN | one cycle: pipeline stalled, FIFO head written

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [ADDR_W-1:0]  fifo_dest_q [DEPTH];
    logic [WORD_W-1:0]  fifo_data_q [DEPTH];

    logic full, empty, push, pop, blocked;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    // lu_ready only looks at full, so a full FIFO never takes a push even
    // when it pops in the same cycle.
    assign push    = lu_valid && !full;
    assign blocked = (state_q == S_IDLE) && !empty && wb_en;
    assign pop     = !empty && ((state_q == S_DRAIN) || !wb_en);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave IDLE on the MAX_WAIT-th consecutive blocked cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (blocked && (wait_q == WAIT_LAST)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: combinational from flops and inputs, forced quiet in reset.
    always_comb begin
        lu_ready   = 1'b1;
        pipe_stall = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        if (rst_n) begin
            lu_ready = !full;
            if (state_q == S_DRAIN) begin
                pipe_stall = 1'b1;
                rf_we      = 1'b1;
                rf_waddr   = fifo_dest_q[rd_ptr_q];
                rf_wdata   = fifo_data_q[rd_ptr_q];
            end else if (wb_en) begin
                rf_we    = 1'b1;
                rf_waddr = wb_dest;
                rf_wdata = mem_r_en ? mem_read_val : alu_res;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_waddr = fifo_dest_q[rd_ptr_q];
                rf_wdata = fifo_data_q[rd_ptr_q];
            end
        end
    end

    // FIFO bookkeeping and starvation counter next values.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wait_d = wait_q;
        if (empty || pop) begin
            wait_d = '0;
        end else if (blocked) begin
            // The counter restarts as DRAIN is entered, so it never exceeds
            // MAX_WAIT-1.
            wait_d = (wait_q == WAIT_LAST) ? '0 : wait_q + WAIT_W'(1);
        end
    end

    // FIFO pointers, occupancy and wait counter; reset discards buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
        end
    end

    // FIFO storage; contents are only read under the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest_q[wr_ptr_q] <= lu_dest;
            fifo_data_q[wr_ptr_q] <= lu_data;
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of DRAIN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_DRAIN) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en, mem_r_en, lu_valid;
    logic [4:0]  wb_dest, lu_dest;
    logic [31:0] alu_res, mem_read_val, lu_data;
    logic        lu_ready, pipe_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;
    ent_t mq[$];

    wb_port_arbiter #(.WORD_W(32), .ADDR_W(5), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .wb_dest      (wb_dest),
        .alu_res      (alu_res),
        .mem_read_val (mem_read_val),
        .lu_valid     (lu_valid),
        .lu_dest      (lu_dest),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .pipe_stall   (pipe_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
`ifdef WB_ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic we, input logic mr, input logic [4:0] wd,
                          input logic [31:0] alu, input logic [31:0] mrv,
                          input logic lv, input logic [4:0] ld, input logic [31:0] ldat);
        wb_en = we; mem_r_en = mr; wb_dest = wd; alu_res = alu; mem_read_val = mrv;
        lu_valid = lv; lu_dest = ld; lu_data = ldat;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0})
            $display("FAIL reset_idle: got %0h expected %0h",
                     {lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata}, {1'b1, 39'd0});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 5'd7, 32'h55, 0, 1, 5'(10 + i), 32'hA0 + 32'(i));
            tick();
        end
        set_in(1, 0, 5'd7, 32'h55, 0, 1, 5'd20, 32'hBB);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0})
            $display("FAIL reset_async: got %0h expected %0h",
                     {lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata}, {1'b1, 39'd0});
        else n_pass++;
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({lu_ready, rf_we} !== 2'b10)
                $display("FAIL reset_stale cyc=%0d: got ready,we=%b expected 10", i, {lu_ready, rf_we});
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_pipeline();
        apply_reset();
        set_in(1, 1, 5'd5, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0, 0);
        n_total++;
        if ({rf_we, rf_waddr, rf_wdata, pipe_stall} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0})
            $display("FAIL pipe_mem: got we=%b a=%0d d=%h expected we=1 a=5 d=deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        set_in(1, 0, 5'd9, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0, 0);
        n_total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h1111_2222})
            $display("FAIL pipe_alu: got we=%b a=%0d d=%h expected we=1 a=9 d=11112222",
                     rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_idle_slot();
        apply_reset();
        set_in(0, 0, 0, 0, 0, 1, 5'd3, 32'h1234);
        n_total++;
        if (rf_we !== 1'b0) $display("FAIL idle_nobypass: got we=%b expected 0", rf_we);
        else n_pass++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h1234})
            $display("FAIL idle_pop: got we=%b a=%0d d=%h expected we=1 a=3 d=1234",
                     rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        tick();
        n_total++;
        if ({rf_we, lu_ready} !== 2'b01)
            $display("FAIL idle_empty: got we,ready=%b expected 01", {rf_we, lu_ready});
        else n_pass++;
        tick();
    endtask

    task automatic test_starvation();
        apply_reset();
        set_in(1, 0, 5'd1, 32'h100, 0, 1, 5'd17, 32'hCAFE_0017);
        tick();
        for (int c = 1; c <= 10; c++) begin
            set_in(1, 0, 5'(c), 32'h100 + 32'(c), 0, 0, 0, 0);
            if (c == 9) begin
                n_total++;
                if ({pipe_stall, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd17, 32'hCAFE_0017})
                    $display("FAIL starve_drain: got stall=%b a=%0d d=%h expected stall=1 a=17 d=cafe0017",
                             pipe_stall, rf_waddr, rf_wdata);
                else n_pass++;
            end else begin
                n_total++;
                if ({pipe_stall, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'(c), 32'h100 + 32'(c)})
                    $display("FAIL starve_pipe cyc=%0d: got stall=%b a=%0d d=%h expected stall=0 a=%0d",
                             c, pipe_stall, rf_waddr, rf_wdata, c);
                else n_pass++;
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (rf_we !== 1'b0) $display("FAIL starve_empty: got we=%b expected 0", rf_we);
        else n_pass++;
        tick();
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 5'd2, 32'h0, 0, 1, 5'(20 + i), 32'hF000 + 32'(i));
            n_total++;
            if (lu_ready !== 1'b1) $display("FAIL full_fill%0d: got ready=%b expected 1", i, lu_ready);
            else n_pass++;
            tick();
        end
        set_in(1, 0, 5'd2, 32'h0, 0, 1, 5'd30, 32'hBAD);
        n_total++;
        if (lu_ready !== 1'b0) $display("FAIL full_ready: got ready=%b expected 0", lu_ready);
        else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            n_total++;
            if ({rf_we, rf_waddr, rf_wdata, lu_ready} !== {1'b1, 5'(20 + i), 32'hF000 + 32'(i), (i != 0)})
                $display("FAIL full_drain%0d: got we=%b a=%0d d=%h ready=%b expected a=%0d ready=%b",
                         i, rf_we, rf_waddr, rf_wdata, lu_ready, 20 + i, (i != 0));
            else n_pass++;
            tick();
        end
        n_total++;
        if (rf_we !== 1'b0) $display("FAIL full_reject: got we=%b expected 0", rf_we);
        else n_pass++;
    endtask

`ifdef WB_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        n_total++;
        if (stall_cycles !== 16'd0) $display("FAIL stats_reset: got %0d expected 0", stall_cycles);
        else n_pass++;
        for (int r = 0; r < 2; r++) begin
            set_in(1, 0, 5'd1, 0, 0, 1, 5'd4, 32'h44);
            tick();
            set_in(1, 0, 5'd1, 0, 0, 0, 0, 0);
            repeat (10) tick();
        end
        n_total++;
        if (stall_cycles !== 16'd2) $display("FAIL stats_count: got %0d expected 2", stall_cycles);
        else n_pass++;
    endtask
`endif

    // Reference model: a queue of pending LU results, a drain flag and a run
    // length of consecutive blocked cycles.
    task automatic test_random();
        bit drain = 0;
        int run = 0;
        int n_drain = 0;
        logic [39:0] exp_v;
        bit pop;
        mq.delete();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            logic        we  = ($urandom_range(0, 99) < 70);
            logic        mr  = 1'($urandom);
            logic [4:0]  wd  = 5'($urandom);
            logic [31:0] alu = $urandom;
            logic [31:0] mrv = $urandom;
            logic        lv  = ($urandom_range(0, 99) < 45);
            logic [4:0]  ld  = 5'($urandom);
            logic [31:0] lda = $urandom;
            bit ready = (mq.size() < DEPTH);
            set_in(we, mr, wd, alu, mrv, lv, ld, lda);
            pop = 0;
            if (drain) begin
                exp_v = {ready, 1'b1, 1'b1, mq[0].d, mq[0].v};
                pop = 1;
            end else if (we) begin
                exp_v = {ready, 1'b0, 1'b1, wd, mr ? mrv : alu};
            end else if (mq.size() > 0) begin
                exp_v = {ready, 1'b0, 1'b1, mq[0].d, mq[0].v};
                pop = 1;
            end else begin
                exp_v = {ready, 1'b0, 1'b0, 5'd0, 32'd0};
            end
            n_total++;
            if ({lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata} !== exp_v)
                $display("FAIL rand cyc=%0d: got %h expected %h", c,
                         {lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata}, exp_v);
            else n_pass++;
            tick();
            if (drain) begin
                n_drain++;
                drain = 0;
                run = 0;
            end else if (mq.size() == 0 || pop) begin
                run = 0;
            end else begin
                run++;
                if (run == MAX_WAIT) begin
                    drain = 1;
                    run = 0;
                end
            end
            if (pop) void'(mq.pop_front());
            if (lv && ready) mq.push_back('{d: ld, v: lda});
        end
        n_total++;
        if (n_drain == 0) $display("FAIL rand_coverage: got %0d drains expected >0", n_drain);
        else n_pass++;
`ifdef WB_ARB_STATS_EN
        n_total++;
        if (stall_cycles !== 16'(n_drain))
            $display("FAIL rand_stats: got %0d expected %0d", stall_cycles, n_drain);
        else n_pass++;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_pipeline();
        test_idle_slot();
        test_starvation();
        test_full();
`ifdef WB_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
